// File: rtl/lcd_line_arbiter_pkg.sv
// Shared types and constants for the LCD line arbiter.
package lcd_line_arbiter_pkg;
  localparam int LCD_LINE_W = 128;

  // Sixteen ASCII spaces: what the panel shows before anything is granted.
  localparam logic [LCD_LINE_W-1:0] LCD_BLANK_LINE = {16{8'h20}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;
endpackage

// File: rtl/lcd_line_arbiter_rr_arb2.sv
// Two-input round-robin pick: on a tie the side not named by i_last wins.
module lcd_rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any,
  output logic o_idx
);
  // Combinational grant; o_idx only meaningful when o_any is high.
  always_comb begin
    o_any = i_req0 | i_req1;
    if (i_req0 && i_req1) o_idx = ~i_last;
    else                  o_idx = i_req1;
  end
endmodule

// File: rtl/lcd_line_arbiter.sv
// Arbitrates two line sources onto one LCD controller, holding each
// written line on the panel for HOLD_CYCLES before the next grant.
module lcd_line_arbiter
  import lcd_line_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES  = 1000,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [LCD_LINE_W-1:0] msg0,
  output logic                  ack0,
  input  logic                  req1,
  input  logic [LCD_LINE_W-1:0] msg1,
  output logic                  ack1,
  input  logic                  lcd_busy,
  output logic                  lcd_load,
  output logic [LCD_LINE_W-1:0] lcd_msg,
  output logic                  owner,
  output logic                  timeout_err
);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [7:0]  BUSY_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t                  r_state, w_next;
  logic [LCD_LINE_W-1:0]   r_msg;
  logic                    r_owner, r_last;
  logic                    r_ack0, r_ack1, r_terr;
  logic [15:0]             r_hcnt;
  logic [7:0]              r_bcnt;
  logic                    w_any, w_idx;
  logic                    w_grant, w_ack, w_timeout, w_hold_done;

  lcd_rr_arb2 u_arb (
    .i_req0 (req0),
    .i_req1 (req1),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_idx)
  );

  // State register; reset aborts any in-flight write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and single-cycle event decode.
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    w_hold_done = 1'b0;
    case (r_state)
      IDLE: if (w_any) begin
        w_grant = 1'b1;
        w_next  = LOAD;
      end
      LOAD: w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (lcd_busy) w_next = WAIT_DONE;
        else if (r_bcnt == BUSY_LAST) begin
          w_timeout = 1'b1;
          w_next    = HOLD;
        end
      end
      WAIT_DONE: if (!lcd_busy) begin
        w_ack  = 1'b1;
        w_next = HOLD;
      end
      HOLD: if (r_hcnt == HOLD_LAST) begin
        w_hold_done = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: message latch, ownership, acks, sticky error, dwell counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_msg   <= LCD_BLANK_LINE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_terr  <= 1'b0;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_ack0 <= w_ack & ~r_owner;
      r_ack1 <= w_ack &  r_owner;
      if (w_grant) begin
        r_msg   <= w_idx ? msg1 : msg0;
        r_owner <= w_idx;
      end
      if (w_timeout)   r_terr <= 1'b1;
      if (w_hold_done) r_last <= r_owner;
      // Counters run only in their own state, so they read zero on entry.
      r_bcnt <= (r_state == WAIT_BUSY) ? r_bcnt + 8'd1  : 8'd0;
      r_hcnt <= (r_state == HOLD)      ? r_hcnt + 16'd1 : 16'd0;
    end
  end

  assign lcd_load    = (r_state == LOAD);
  assign lcd_msg     = r_msg;
  assign owner       = r_owner;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign timeout_err = r_terr;
endmodule

// File: doc/lcd_line_arbiter.md
LCD_LINE_ARBITER -- requirements
Module: lcd_line_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1000, giving the minimum cycles a granted message stays on the display before the next grant (legal range 1..65535).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 15, giving the maximum cycles to wait for lcd_busy to rise after lcd_load (legal range 1..255).
REQ-003 clock  input  1  system clock, rising-edge active.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0  input  1  requester 0 (prompt/status path) wants a line shown; level-sensitive.
REQ-006 msg0  input  128  requester 0 line, 16 ASCII chars, char 0 in [7:0].
REQ-007 ack0  output  1  one-cycle pulse: requester 0's line has been written to the LCD.
REQ-008 req1  input  1  requester 1 (CPU print path) wants a line shown; level-sensitive.
REQ-009 msg1  input  128  requester 1 line, same packing as msg0.
REQ-010 ack1  output  1  one-cycle pulse: requester 1's line has been written.
REQ-011 lcd_busy  input  1  LCD controller is refreshing the panel.
REQ-012 lcd_load  output  1  one-cycle strobe: LCD controller captures lcd_msg and starts a refresh.
REQ-013 lcd_msg  output  128  registered line sent to the LCD controller.
REQ-014 owner  output  1  index of the requester currently or last granted.
REQ-015 timeout_err  output  1  sticky flag: lcd_busy never rose within BUSY_TIMEOUT.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-017 In IDLE with any req high, the block SHALL grant one requester, latch its msg into lcd_msg, set owner, and go to LOAD on the same edge.
REQ-018 Arbitration SHALL be round-robin: with both req high, the requester not named by the internal last-grant pointer wins; with one req high, that requester wins.
REQ-019 msg0/msg1 SHALL be sampled only on the grant edge; later changes SHALL NOT affect lcd_msg until the next grant.
REQ-020 In LOAD, lcd_load SHALL be 1 for exactly one cycle, then the FSM goes to WAIT_BUSY; lcd_load SHALL be 0 in every other state.
REQ-021 In WAIT_BUSY, lcd_busy=1 SHALL move to WAIT_DONE; after BUSY_TIMEOUT cycles without busy, the FSM SHALL set timeout_err and go to HOLD without acking.
REQ-022 In WAIT_DONE, lcd_busy=0 SHALL move to HOLD and pulse ack of owner for one cycle on the transition edge.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles (16-bit counter, cleared on entry), then update last-grant pointer to owner and return to IDLE.
REQ-024 Requesters SHALL drop req within HOLD_CYCLES of ack; a req still high when HOLD returns to IDLE SHALL be treated as a new request.
REQ-025 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the in-flight write.
REQ-026 Grant-to-lcd_load latency SHALL be 1 cycle; ack0 and ack1 SHALL never be high in the same cycle.
REQ-027 timeout_err SHALL clear only on reset.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE immediately, including mid-write, with no ack issued for the aborted write.
REQ-029 Reset values: lcd_load=0, ack0=0, ack1=0, owner=0, timeout_err=0, lcd_msg=sixteen 8'h20 (spaces), last-grant pointer=1 (requester 0 wins first tie), counters=0.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the LCD_BLANK_LINE constant (16x 8'h20), and LCD_LINE_W=128.
REQ-031 One sub-module SHALL be natural: lcd_rr_arb2 (two-input round-robin grant from req pair and last pointer, combinational); all other logic SHALL be inline.

Verification (HOLD_CYCLES=4, BUSY_TIMEOUT=15)
REQ-032 req0=1, msg0="READY" padded -> lcd_load pulses at cycle 2; busy 3 cycles high then low -> ack0 one pulse; IDLE reached 4 cycles later.
REQ-033 req0 and req1 both held high from reset -> grant order 0,1,0,1; owner toggles; never two acks in one cycle.
REQ-034 msg1 changed one cycle after grant -> lcd_msg keeps the value sampled at grant.
REQ-035 lcd_busy held 0 after lcd_load -> timeout_err=1 after 15 cycles, no ack, HOLD entered; next request still served.
REQ-036 reset asserted during WAIT_DONE -> all outputs at reset values asynchronously; no ack; lcd_msg=spaces.
REQ-037 req1 pulsed 1 cycle while the FSM is in HOLD for requester 0 -> ignored, no grant to requester 1.
